layer_seq_ctrl: RTL and testbench
=================================

Name: layer_seq_ctrl

Overview:
Top-level phase sequencer for the accelerator. It is the parametrised successor of the single-pass weight/input/compute controller. It runs NUM_LAYERS layers, each over a run-time batch count. Weights load once per layer; inputs, compute and write-back repeat once per batch. It issues one-cycle start pulses to the loader, PE array and write-back engines, and consumes their *_finish pulses.

Parameters:
NUM_LAYERS, 4, layers sequenced per run (>=1)
BATCH_W, 8, width of the batch-count input
LAYER_W, $clog2(NUM_LAYERS) (min 1), width of layer_idx
TIMEOUT_CYCLES, 4096, watchdog limit per phase (used only with CTRL_WATCHDOG_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle run request
num_batches  in  BATCH_W  batches per layer, sampled on accepted start
read_weights_finish  in  1  weight load complete pulse
read_inputs_finish  in  1  input load complete pulse
compute_finish  in  1  PE array complete pulse
write_back_finish  in  1  output store complete pulse
load_weights_start  out  1  pulse: begin weight load
load_inputs_start  out  1  pulse: begin input load
compute_start  out  1  pulse: begin compute
write_back_start  out  1  pulse: begin write-back
layer_idx  out  LAYER_W  current layer
batch_idx  out  BATCH_W  current batch
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at run completion
error  out  1  watchdog fault, sticky (0 when feature off)

Behaviour:
- States: IDLE, LOAD_W, LOAD_I, COMPUTE, WRITE_BACK, FINISH.
- Reset (rst=0, async) forces the following immediately and aborts any run: state=IDLE, all outputs 0, indices 0, batch limit register 0.
- IDLE, start=1: latch num_batches, with 0 treated as 1. Clear indices. Go to LOAD_W.
- Each *_start pulse is high exactly in the first cycle after entering its state. It is registered, so it appears one cycle after the transition edge.
- LOAD_W: on read_weights_finish, go to LOAD_I.
- LOAD_I: on read_inputs_finish, go to COMPUTE.
- COMPUTE: on compute_finish, go to WRITE_BACK.
- WRITE_BACK: on write_back_finish, then:
  - batch_idx < limit-1: batch_idx++, go to LOAD_I.
  - else if layer_idx < NUM_LAYERS-1: layer_idx++, batch_idx=0, go to LOAD_W.
  - else: go to FINISH.
- FINISH: done=1 for one cycle, then IDLE. Indices hold their final values until the next start.
- A finish pulse arriving in any other state is ignored, including a finish for a phase that has already passed.
- A finish arriving in the same cycle as its start pulse is accepted.
- start while busy is ignored, and num_batches is not re-sampled.
- Minimum phase time is 1 cycle. Back-to-back finish pulses advance one state per cycle.
- No combinational path from any input to any output.

Optional Feature:
- Macro: CTRL_WATCHDOG_EN.
- Defined:
  - A phase counter clears on every state entry and increments each cycle spent in LOAD_W, LOAD_I, COMPUTE or WRITE_BACK.
  - When it reaches TIMEOUT_CYCLES without the matching finish: error=1, state goes to IDLE, no done pulse.
  - error stays set until the next accepted start, which clears it.
  - A finish that arrives on the timeout cycle wins; no error is raised.
- Undefined: no counter logic; error is tied to 0.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum (3-bit encoding, IDLE=0);
  - the TIMEOUT default;
  - a function computing the layer index width with minimum 1.
- One natural sub-module, phase_watchdog: a counter with clear/enable/expired outputs, instantiated only under CTRL_WATCHDOG_EN. The FSM and index counters stay in layer_seq_ctrl.

Test Plan:
- NUM_LAYERS=2, num_batches=3, finishes returned 5 cycles after each start pulse:
  - pulse counts: load_weights_start 2, load_inputs_start/compute_start/write_back_start 6 each;
  - done exactly once;
  - final layer_idx=1, batch_idx=2.
- num_batches=0: behaves as 1 batch. With NUM_LAYERS=4: 4 weight loads, 4 input loads, done pulses.
- Stray compute_finish during LOAD_W, and start asserted mid-run: state unchanged, no extra pulses, batch limit unchanged.
- rst driven low mid-COMPUTE, asynchronously between clock edges: outputs 0 and busy=0 before the next edge. A new start runs cleanly from layer 0.
- Finish in the same cycle as its start pulse, every phase, NUM_LAYERS=1, num_batches=1: done occurs 10 cycles after the start edge.
- CTRL_WATCHDOG_EN, TIMEOUT_CYCLES=16, read_inputs_finish withheld:
  - error=1 at cycle 16 of LOAD_I; state IDLE; no done pulse;
  - next start clears error.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared types and constants for the layer sequencer (layer_seq_ctrl) and
// its phase watchdog.
//   state_t                : FSM state encoding, 3 bits, IDLE = 0
//   DEFAULT_TIMEOUT_CYCLES : default per-phase watchdog limit
//   layer_idx_width()      : width of the layer index, never below 1 bit
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_W     = 3'd1,
    ST_LOAD_I     = 3'd2,
    ST_COMPUTE    = 3'd3,
    ST_WRITE_BACK = 3'd4,
    ST_FINISH     = 3'd5
  } state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

  // A single-layer build still needs a 1-bit index port.
  function automatic int layer_idx_width(input int num_layers);
    return (num_layers <= 1) ? 1 : $clog2(num_layers);
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// phase_watchdog
// Counts the cycles spent in one sequencer phase and flags the cycle on
// which the phase has lasted TIMEOUT_CYCLES cycles.
//   clk     in  : clock, rising edge
//   rst     in  : asynchronous active-low reset
//   clear   in  : restart the count (state entry)
//   enable  in  : count this cycle (a watched phase is active)
//   expired out : this cycle is the TIMEOUT_CYCLES-th cycle of the phase
module phase_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // The count is 0 during the first cycle of a phase, so the limit is hit
  // when it reads TIMEOUT_CYCLES-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl
// Top-level phase sequencer. Runs NUM_LAYERS layers; each layer loads its
// weights once, then repeats input load / compute / write-back once per
// batch. Engines are kicked with registered one-cycle *_start pulses and
// report back with *_finish pulses.
// Optional feature macro: CTRL_WATCHDOG_EN (per-phase timeout -> sticky error).
// Ports:
//   clk, rst (async active-low)
//   start, num_batches           : run request and batches per layer
//   read_weights_finish, read_inputs_finish, compute_finish,
//   write_back_finish            : engine completion pulses
//   load_weights_start, load_inputs_start, compute_start,
//   write_back_start             : engine start pulses
//   layer_idx, batch_idx         : current position in the run
//   busy, done, error            : status
module layer_seq_ctrl
  import ctrl_pkg::*;
#(
  parameter int NUM_LAYERS     = 4,
  parameter int BATCH_W        = 8,
  parameter int LAYER_W        = layer_idx_width(NUM_LAYERS),
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BATCH_W-1:0] num_batches,
  input  logic               read_weights_finish,
  input  logic               read_inputs_finish,
  input  logic               compute_finish,
  input  logic               write_back_finish,
  output logic               load_weights_start,
  output logic               load_inputs_start,
  output logic               compute_start,
  output logic               write_back_start,
  output logic [LAYER_W-1:0] layer_idx,
  output logic [BATCH_W-1:0] batch_idx,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  state_t             state_q, state_d;
  logic               first_q;
  logic [BATCH_W-1:0] limit_q, limit_d;
  logic [BATCH_W-1:0] batch_q, batch_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic               timeout_abort;
  logic               wd_expired;

  logic lws_d, lis_d, cs_d, wbs_d, done_d;
  logic lws_q, lis_q, cs_q, wbs_q, done_q;

`ifdef CTRL_WATCHDOG_EN
  logic in_phase;
  logic error_q;

  assign in_phase = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_I) ||
                    (state_q == ST_COMPUTE) || (state_q == ST_WRITE_BACK);

  // Restarted on every state change, so each phase gets its own budget.
  phase_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_d != state_q),
    .enable (in_phase),
    .expired(wd_expired)
  );

  // Sticky fault flag; only a newly accepted run clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error_q <= 1'b0;
    end else if (timeout_abort) begin
      error_q <= 1'b1;
    end else if ((state_q == ST_IDLE) && start) begin
      error_q <= 1'b0;
    end
  end

  assign error = error_q;
`else
  logic unused_wd;

  assign wd_expired = 1'b0;
  assign unused_wd  = ^{TIMEOUT_CYCLES, timeout_abort};
  assign error      = 1'b0;
`endif

  // State and run-position registers. first_q marks the first cycle spent
  // in a newly entered state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
      limit_q <= '0;
      batch_q <= '0;
      layer_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q);
      limit_q <= limit_d;
      batch_q <= batch_d;
      layer_q <= layer_d;
    end
  end

  // Next state and index updates. Finish pulses are only looked at in the
  // state waiting for them, so stray or late pulses fall through.
  always_comb begin
    state_d       = state_q;
    limit_d       = limit_q;
    batch_d       = batch_q;
    layer_d       = layer_q;
    timeout_abort = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_W;
          limit_d = (num_batches == '0) ? BATCH_W'(1) : num_batches;
          batch_d = '0;
          layer_d = '0;
        end
      end
      ST_LOAD_W: begin
        if (read_weights_finish) state_d = ST_LOAD_I;
      end
      ST_LOAD_I: begin
        if (read_inputs_finish) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (compute_finish) state_d = ST_WRITE_BACK;
      end
      ST_WRITE_BACK: begin
        if (write_back_finish) begin
          if (batch_q < (limit_q - BATCH_W'(1))) begin
            batch_d = batch_q + BATCH_W'(1);
            state_d = ST_LOAD_I;
          end else if (layer_q < LAST_LAYER) begin
            layer_d = layer_q + LAYER_W'(1);
            batch_d = '0;
            state_d = ST_LOAD_W;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A finish on the expiry cycle has already moved state_d on, so it wins.
    if (wd_expired && (state_d == state_q)) begin
      state_d       = ST_IDLE;
      timeout_abort = 1'b1;
    end
  end

  // Pulse requests: an engine start fires from the first cycle of its
  // state, and registering it keeps inputs off the output paths.
  always_comb begin
    lws_d  = first_q && (state_q == ST_LOAD_W);
    lis_d  = first_q && (state_q == ST_LOAD_I);
    cs_d   = first_q && (state_q == ST_COMPUTE);
    wbs_d  = first_q && (state_q == ST_WRITE_BACK);
    done_d = (state_q == ST_FINISH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lws_q  <= 1'b0;
      lis_q  <= 1'b0;
      cs_q   <= 1'b0;
      wbs_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      lws_q  <= lws_d;
      lis_q  <= lis_d;
      cs_q   <= cs_d;
      wbs_q  <= wbs_d;
      done_q <= done_d;
    end
  end

  assign load_weights_start = lws_q;
  assign load_inputs_start  = lis_q;
  assign compute_start      = cs_q;
  assign write_back_start   = wbs_q;
  assign done               = done_q;
  assign busy               = (state_q != ST_IDLE);
  assign layer_idx          = layer_q;
  assign batch_idx          = batch_q;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// tb_layer_seq_ctrl
// Bench for layer_seq_ctrl with NUM_LAYERS=2, BATCH_W=8, TIMEOUT_CYCLES=16.
// A phase-level model of the run is compared with the DUT on every falling
// edge; directed scenarios add hand-computed literal checks. The watchdog
// scenario is included when CTRL_WATCHDOG_EN is defined.
module tb_layer_seq_ctrl;

  localparam int NL = 2;
  localparam int BW = 8;
  localparam int LW = 1;
  localparam int TO = 16;
`ifdef CTRL_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  localparam int P_IDLE = 0;
  localparam int P_LW   = 1;
  localparam int P_LI   = 2;
  localparam int P_CP   = 3;
  localparam int P_WB   = 4;
  localparam int P_FIN  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] num_batches = '0;
  logic          rwf = 1'b0, rif = 1'b0, cf = 1'b0, wbf = 1'b0;
  logic          load_weights_start, load_inputs_start, compute_start, write_back_start;
  logic [LW-1:0] layer_idx;
  logic [BW-1:0] batch_idx;
  logic          busy, done, error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  layer_seq_ctrl #(
    .NUM_LAYERS    (NL),
    .BATCH_W       (BW),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .num_batches        (num_batches),
    .read_weights_finish(rwf),
    .read_inputs_finish (rif),
    .compute_finish     (cf),
    .write_back_finish  (wbf),
    .load_weights_start (load_weights_start),
    .load_inputs_start  (load_inputs_start),
    .compute_start      (compute_start),
    .write_back_start   (write_back_start),
    .layer_idx          (layer_idx),
    .batch_idx          (batch_idx),
    .busy               (busy),
    .done               (done),
    .error              (error)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Phase-level model: which phase the run is in, how long it has been
  // there, and where it is in the layer/batch walk. A start pulse is
  // expected in the cycle following the first cycle of its phase.
  int m_phase = P_IDLE, m_age = 0, m_prev_phase = P_IDLE, m_prev_age = 1;
  int m_layer = 0, m_batch = 0, m_limit = 0;
  bit m_error = 1'b0;

  task automatic model_step();
    int nxt;
    m_prev_phase = m_phase;
    m_prev_age   = m_age;
    nxt          = m_phase;
    case (m_phase)
      P_IDLE: if (start) begin
        m_limit = (num_batches == 0) ? 1 : int'(num_batches);
        m_layer = 0;
        m_batch = 0;
        m_error = 1'b0;
        nxt     = P_LW;
      end
      P_LW: if (rwf) nxt = P_LI;
      P_LI: if (rif) nxt = P_CP;
      P_CP: if (cf) nxt = P_WB;
      P_WB: if (wbf) begin
        if (m_batch < m_limit - 1) begin
          m_batch++;
          nxt = P_LI;
        end else if (m_layer < NL - 1) begin
          m_layer++;
          m_batch = 0;
          nxt = P_LW;
        end else begin
          nxt = P_FIN;
        end
      end
      default: nxt = P_IDLE;
    endcase
    if (WD_ON && m_phase >= P_LW && m_phase <= P_WB && nxt == m_phase && m_age + 1 >= TO) begin
      m_error = 1'b1;
      nxt     = P_IDLE;
    end
    m_age   = (nxt != m_phase) ? 0 : m_age + 1;
    m_phase = nxt;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = P_IDLE; m_age = 0; m_prev_phase = P_IDLE; m_prev_age = 1;
      m_layer = 0; m_batch = 0; m_limit = 0; m_error = 1'b0;
    end else begin
      model_step();
    end
  end

  // Compare the DUT against the model every cycle.
  always @(negedge clk) begin
    check_output("busy", busy, m_phase != P_IDLE);
    check_output("layer_idx", layer_idx, m_layer);
    check_output("batch_idx", batch_idx, m_batch);
    check_output("load_weights_start", load_weights_start, m_prev_phase == P_LW && m_prev_age == 0);
    check_output("load_inputs_start", load_inputs_start, m_prev_phase == P_LI && m_prev_age == 0);
    check_output("compute_start", compute_start, m_prev_phase == P_CP && m_prev_age == 0);
    check_output("write_back_start", write_back_start, m_prev_phase == P_WB && m_prev_age == 0);
    check_output("done", done, m_prev_phase == P_FIN);
    check_output("error", error, m_error);
  end

  // Pulse counters, read as differences by the scenarios.
  int n_lws = 0, n_lis = 0, n_cs = 0, n_wbs = 0, n_done = 0;
  always @(negedge clk) begin
    if (load_weights_start === 1'b1) n_lws++;
    if (load_inputs_start === 1'b1)  n_lis++;
    if (compute_start === 1'b1)      n_cs++;
    if (write_back_start === 1'b1)   n_wbs++;
    if (done === 1'b1)               n_done++;
  end

  // Engine responder: each start pulse is answered resp_delay cycles later
  // (0 = in the same cycle as the pulse).
  int resp_delay = 5;
  bit hold_li = 1'b0;
  bit stray_cf = 1'b0;
  int c_w = 0, c_i = 0, c_c = 0, c_b = 0;
  always @(negedge clk) begin
    bit fw, fi, fc, fb;
    fw = 1'b0; fi = 1'b0; fc = 1'b0; fb = 1'b0;
    if (!rst) begin
      c_w = 0; c_i = 0; c_c = 0; c_b = 0;
    end else begin
      if (c_w > 0) begin c_w--; if (c_w == 0) fw = 1'b1; end
      if (c_i > 0) begin c_i--; if (c_i == 0) fi = 1'b1; end
      if (c_c > 0) begin c_c--; if (c_c == 0) fc = 1'b1; end
      if (c_b > 0) begin c_b--; if (c_b == 0) fb = 1'b1; end
      if (load_weights_start === 1'b1) begin if (resp_delay == 0) fw = 1'b1; else c_w = resp_delay; end
      if (load_inputs_start === 1'b1)  begin if (resp_delay == 0) fi = 1'b1; else c_i = resp_delay; end
      if (compute_start === 1'b1)      begin if (resp_delay == 0) fc = 1'b1; else c_c = resp_delay; end
      if (write_back_start === 1'b1)   begin if (resp_delay == 0) fb = 1'b1; else c_b = resp_delay; end
    end
    rwf = fw;
    rif = fi && !hold_li;
    cf  = fc || stray_cf;
    wbf = fb;
  end

  // Issue a one-cycle start request; returns on the falling edge right
  // after the accepting rising edge.
  task automatic apply_stimulus(input int nb);
    start       = 1'b1;
    num_batches = BW'(nb);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_output({name, "_done_in_budget"}, k < budget, 1);
  endtask

  int b_lws, b_lis, b_cs, b_wbs, b_done;
  task automatic snap();
    b_lws = n_lws; b_lis = n_lis; b_cs = n_cs; b_wbs = n_wbs; b_done = n_done;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not end, expected finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int k;
    // Reset state
    repeat (2) @(negedge clk);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_layer", layer_idx, 0);
    check_output("rst_batch", batch_idx, 0);
    check_output("rst_lws", load_weights_start, 0);
    check_output("rst_error", error, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Two layers x three batches, finishes 5 cycles after each pulse
    resp_delay = 5;
    snap();
    apply_stimulus(3);
    wait_done("run3", 2000);
    check_output("run3_lws", n_lws - b_lws, 2);
    check_output("run3_lis", n_lis - b_lis, 6);
    check_output("run3_cs", n_cs - b_cs, 6);
    check_output("run3_wbs", n_wbs - b_wbs, 6);
    check_output("run3_layer", layer_idx, 1);
    check_output("run3_batch", batch_idx, 2);
    repeat (3) @(negedge clk);
    check_output("run3_done_once", n_done - b_done, 1);
    check_output("run3_hold_layer", layer_idx, 1);

    // num_batches = 0 runs as one batch per layer
    resp_delay = 2;
    snap();
    apply_stimulus(0);
    wait_done("nb0", 2000);
    check_output("nb0_lws", n_lws - b_lws, 2);
    check_output("nb0_lis", n_lis - b_lis, 2);
    check_output("nb0_batch", batch_idx, 0);
    @(negedge clk);
    check_output("nb0_done_once", n_done - b_done, 1);

    // Stray compute_finish in LOAD_W and a re-start mid-run are ignored
    resp_delay = 5;
    snap();
    apply_stimulus(2);
    k = 0;
    while (load_weights_start !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    check_output("stray_lws_seen", k < 50, 1);
    stray_cf    = 1'b1;
    start       = 1'b1;
    num_batches = BW'(7);
    @(negedge clk);
    @(negedge clk);
    stray_cf = 1'b0;
    start    = 1'b0;
    wait_done("stray", 2000);
    check_output("stray_lws", n_lws - b_lws, 2);
    check_output("stray_lis", n_lis - b_lis, 4);
    check_output("stray_cs", n_cs - b_cs, 4);
    check_output("stray_wbs", n_wbs - b_wbs, 4);
    check_output("stray_batch", batch_idx, 1);
    @(negedge clk);

    // Asynchronous reset during COMPUTE of layer 1
    resp_delay = 5;
    apply_stimulus(1);
    k = 0;
    while (!(compute_start === 1'b1 && layer_idx === 1'b1) && k < 200) begin @(negedge clk); k++; end
    check_output("arst_cs_seen", k < 200, 1);
    check_output("arst_busy_before", busy, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("arst_busy", busy, 0);
    check_output("arst_layer", layer_idx, 0);
    check_output("arst_batch", batch_idx, 0);
    check_output("arst_lws", load_weights_start, 0);
    check_output("arst_lis", load_inputs_start, 0);
    check_output("arst_cs", compute_start, 0);
    check_output("arst_wbs", write_back_start, 0);
    check_output("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    snap();
    apply_stimulus(1);
    check_output("arst_restart_layer", layer_idx, 0);
    check_output("arst_restart_busy", busy, 1);
    wait_done("arst_rerun", 2000);
    check_output("arst_rerun_lws", n_lws - b_lws, 2);
    @(negedge clk);
    check_output("arst_rerun_done", n_done - b_done, 1);

    // Finishes in the same cycle as each start pulse: every phase takes two
    // cycles, so done is seen on falling edge 8*NL+2 after the start edge.
    resp_delay = 0;
    apply_stimulus(1);
    k = 1;
    while (done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    check_output("same_cycle_done_at", k, 18);
    @(negedge clk);

`ifdef CTRL_WATCHDOG_EN
    // Input load never finishes: error on the 16th cycle of LOAD_I
    resp_delay = 1;
    hold_li    = 1'b1;
    snap();
    apply_stimulus(1);
    k = 0;
    while (load_inputs_start !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    check_output("wd_lis_seen", k < 50, 1);
    k = 0;
    while (error !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    check_output("wd_error_at", k, 15);
    check_output("wd_busy", busy, 0);
    @(negedge clk);
    check_output("wd_no_done", n_done - b_done, 0);
    check_output("wd_error_sticky", error, 1);
    hold_li = 1'b0;
    apply_stimulus(1);
    check_output("wd_error_cleared", error, 0);
    wait_done("wd_rerun", 2000);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
